prog_pulse_divider: RTL and testbench

PROG_PULSE_DIVIDER -- requirements
Module: prog_pulse_divider

---
 rtl/prog_pulse_divider.sv | 107 ++++++++++
 tb/tb_prog_pulse_divider.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/prog_pulse_divider.sv
// Programmable divider for an asynchronous pulse stream: synchronises pulse_in,
// counts rising edges and emits a strobe or a 50% toggle every D_act edges.
module prog_pulse_divider #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEFAULT_DIV = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] div_value,
    input  logic             div_load,
    output logic             div_out,
    output logic             strobe_out,
    output logic             load_pending,
    output logic [CNT_W-1:0] event_count
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       div_q, div_d;
    logic [WIDTH-1:0]       pend_q, pend_d;
    logic                   pflag_q, pflag_d;
    logic                   tog_q, tog_d;
    logic                   strobe_q;
    logic                   div_out_q;
    logic [CNT_W-1:0]       ev_q, ev_d;

    logic                   rise;
    logic [WIDTH-1:0]       d_act;
    logic                   term;

    assign rise  = sync_q[SYNC_STAGES-1] & ~edge_q;
    // A stored divisor of zero behaves as divide-by-one.
    assign d_act = (div_q == '0) ? WIDTH'(1) : div_q;
    assign term  = en & rise & (cnt_q == (d_act - WIDTH'(1)));

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        pend_d  = pend_q;
        pflag_d = pflag_q;
        if (!en) begin
            if (div_load) begin
                div_d   = div_value;
                cnt_d   = '0;
                pflag_d = 1'b0;
            end
        end else begin
            if (rise) begin
                cnt_d = term ? '0 : cnt_q + WIDTH'(1);
            end
            // New divisors only take over at a period boundary; a load on the
            // boundary itself wins over any older pending value.
            if (term) begin
                if (div_load) begin
                    div_d = div_value;
                end else if (pflag_q) begin
                    div_d = pend_q;
                end
                pflag_d = 1'b0;
            end else if (div_load) begin
                pend_d  = div_value;
                pflag_d = 1'b1;
            end
        end
        tog_d = tog_q ^ term;
        ev_d  = ev_q + {{(CNT_W-1){1'b0}}, term};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            edge_q    <= 1'b0;
            cnt_q     <= '0;
            div_q     <= WIDTH'(DEFAULT_DIV);
            pend_q    <= '0;
            pflag_q   <= 1'b0;
            tog_q     <= 1'b0;
            strobe_q  <= 1'b0;
            div_out_q <= 1'b0;
            ev_q      <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            edge_q    <= sync_q[SYNC_STAGES-1];
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pend_q    <= pend_d;
            pflag_q   <= pflag_d;
            tog_q     <= tog_d;
            strobe_q  <= term;
            // Toggle runs regardless of mode, so switching mode only picks a source.
            div_out_q <= mode ? tog_d : term;
            ev_q      <= ev_d;
        end
    end

    assign div_out      = div_out_q;
    assign strobe_out   = strobe_q;
    assign load_pending = pflag_q;
    assign event_count  = ev_q;

endmodule

// File: tb/tb_prog_pulse_divider.sv
// Directed scoreboard bench for prog_pulse_divider: each pulse expected to end a
// period queues the strobe time, div_out and event_count the monitor must see.
module tb_prog_pulse_divider;

    localparam int WIDTH = 16;
    localparam int SS    = 2;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pulse_in = 1'b0;
    logic             en = 1'b1;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] div_value = '0;
    logic             div_load = 1'b0;
    logic             div_out, strobe_out, load_pending;
    logic [CW-1:0]    event_count;

    prog_pulse_divider #(
        .WIDTH(WIDTH), .SYNC_STAGES(SS), .DEFAULT_DIV(2), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .en(en), .mode(mode),
        .div_value(div_value), .div_load(div_load), .div_out(div_out),
        .strobe_out(strobe_out), .load_pending(load_pending),
        .event_count(event_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          at;
        logic        dout;
        logic [CW-1:0] ev;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_ev = '0;
    logic          exp_tog = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && strobe_out) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("strobe_cycle", cyc, e.at);
                check("div_out", int'(div_out), int'(e.dout));
                check("event_count", int'(event_count), int'(e.ev));
                $display("strobe at cycle %0d div_out=%0d event_count=%0d", cyc, div_out, event_count);
            end
        end
    end

    // One pulse_in edge; term marks a hand-identified terminal edge. An optional
    // div_load is raised in the cycle the edge detector fires.
    task automatic pulse(input bit term, input bit ld = 1'b0, input logic [WIDTH-1:0] lv = '0);
        exp_t e;
        @(negedge clk);
        if (term) begin
            exp_ev  = exp_ev + 1'b1;
            exp_tog = ~exp_tog;
            e.at    = cyc + SS + 1;
            e.dout  = mode ? exp_tog : 1'b1;
            e.ev    = exp_ev;
            q.push_back(e);
        end
        pulse_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        div_load  = ld;
        div_value = lv;
        pulse_in  = 1'b0;
        @(negedge clk);
        div_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_idle(input logic [WIDTH-1:0] v);
        @(negedge clk);
        en = 1'b0; div_load = 1'b1; div_value = v;
        @(negedge clk);
        div_load = 1'b0; en = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_strobe"}, int'(strobe_out), 0);
        check({tag, "_div_out"}, int'(div_out), 0);
        check({tag, "_load_pending"}, int'(load_pending), 0);
        check({tag, "_event_count"}, int'(event_count), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Default divide-by-2, strobe mode: 8 edges, terminals on even edges.
        for (int i = 1; i <= 8; i++) pulse(i % 2 == 0);
        check("t1_event_count", int'(event_count), 4);

        // Divide-by-5 toggle mode across two full output periods.
        mode = 1'b1;
        load_idle(5);
        for (int i = 1; i <= 20; i++) pulse(i % 5 == 0);
        check("t2_final_div_out", int'(div_out), 0);

        // Mid-period load: D=4, load 3 after one edge.
        load_idle(4);
        pulse(0);
        @(negedge clk); div_load = 1'b1; div_value = 3;
        @(negedge clk); div_load = 1'b0;
        check("t3_pending_set", int'(load_pending), 1);
        pulse(0); pulse(0); pulse(1);
        check("t3_pending_clear", int'(load_pending), 0);
        pulse(0); pulse(0); pulse(1);

        // Load coincident with the terminal edge goes straight in.
        pulse(0); pulse(0); pulse(1, 1'b1, 2);
        check("t3b_pending_stays_0", int'(load_pending), 0);
        pulse(0); pulse(1);

        // D=0 and D=1 both strobe on every edge; event_count wraps 15 -> 0 -> 1.
        load_idle(0);
        for (int i = 0; i < 3; i++) pulse(1);
        mode = 1'b0;
        load_idle(1);
        pulse(1); pulse(1);
        check("wrap_event_count", int'(event_count), 1);

        // en low for 3 edges at cnt=2 with D=4: those edges are dropped.
        load_idle(4);
        pulse(0); pulse(0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) pulse(0);
        en = 1'b1;
        pulse(0); pulse(1);

        // Reset mid-period, then the default divisor must be back in force.
        pulse(0);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        check_reset_state("mid_reset");
        rst_n = 1'b1;
        exp_ev = '0; exp_tog = 1'b0;
        pulse(0); pulse(1);
        check("post_reset_event_count", int'(event_count), 1);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
